// File: rtl/wb_resp_pkg.sv
// Shared types and CFG-register layout for the wb_resp_mem WISHBONE responder.
package wb_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WS_LSB   = 0;
    localparam int WS_MSB   = 3;
    localparam int RTY1_BIT = 4;
    localparam int WP_BIT   = 5;
    localparam int CFG_W    = 6;
    localparam int CFG_ADDR = 0;

    // CFG as seen on the read bus: implemented bits in the low positions, zeros above.
    function automatic logic [15:0] cfg_to_bus(input logic [CFG_W-1:0] cfg);
        return {{(16 - CFG_W){1'b0}}, cfg};
    endfunction

endpackage

// File: rtl/wb_resp_regfile.sv
// Byte-lane writable data-word storage with asynchronous clear; combinational read.
module wb_resp_regfile #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AWIDTH-1:0]     adr,
    input  logic [DWIDTH/8-1:0]   sel,
    input  logic [DWIDTH-1:0]     wdat,
    output logic [DWIDTH-1:0]     rdat
);

    localparam int NB    = DWIDTH / 8;
    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (sel[b]) begin
                    mem[adr][b*8 +: 8] <= wdat[b*8 +: 8];
                end
            end
        end
    end

    assign rdat = mem[adr];

endmodule

// File: rtl/wb_resp_mem.sv
// WISHBONE slave with configurable wait states, one-shot retry, write protect and ack counter.
module wb_resp_mem
    import wb_resp_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 3
) (
    input  logic                  wb_clk_i,
    input  logic                  arst_i,
    input  logic [AWIDTH-1:0]     wb_adr_i,
    input  logic [DWIDTH-1:0]     wb_dat_i,
    output logic [DWIDTH-1:0]     wb_dat_o,
    input  logic                  wb_we_i,
    input  logic [DWIDTH/8-1:0]   wb_sel_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    output logic [7:0]            acc_cnt_o
);

    localparam int NB = DWIDTH / 8;

    state_t             state;
    logic [3:0]         wcnt;
    logic [CFG_W-1:0]   cfg;
    logic [AWIDTH-1:0]  adr_p0;
    logic [DWIDTH-1:0]  dat_p0;
    logic               we_p0;
    logic [NB-1:0]      sel_p0;
    logic [DWIDTH-1:0]  rf_rdat;
    logic               term_busy;
    logic               req;
    logic               is_cfg;
    logic               do_rty;
    logic               do_err;
    logic               rf_we;

    // A termination still on the bus keeps IDLE from accepting the master's trailing strobe.
    assign term_busy = wb_ack_o | wb_err_o | wb_rty_o;
    assign req       = wb_cyc_i & wb_stb_i & ~term_busy;
    assign is_cfg    = (adr_p0 == AWIDTH'(CFG_ADDR));
    assign do_rty    = cfg[RTY1_BIT];
    assign do_err    = we_p0 & ~is_cfg & cfg[WP_BIT];
    assign rf_we     = (state == RESP) & we_p0 & ~is_cfg & ~do_rty & ~do_err;

    wb_resp_regfile #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_regfile (
        .clk   (wb_clk_i),
        .rst_n (arst_i),
        .we    (rf_we),
        .adr   (adr_p0),
        .sel   (sel_p0),
        .wdat  (dat_p0),
        .rdat  (rf_rdat)
    );

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state     <= IDLE;
            wcnt      <= '0;
            cfg       <= '0;
            adr_p0    <= '0;
            dat_p0    <= '0;
            we_p0     <= 1'b0;
            sel_p0    <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_rty_o  <= 1'b0;
            wb_dat_o  <= '0;
            acc_cnt_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_rty_o <= 1'b0;
            wb_dat_o <= '0;
            case (state)
                IDLE: begin
                    if (req) begin
                        adr_p0 <= wb_adr_i;
                        dat_p0 <= wb_dat_i;
                        we_p0  <= wb_we_i;
                        sel_p0 <= wb_sel_i;
                        wcnt   <= cfg[WS_MSB:WS_LSB];
                        state  <= (cfg[WS_MSB:WS_LSB] != 4'd0) ? WAIT : RESP;
                    end
                end
                WAIT: begin
                    if (!(wb_cyc_i && wb_stb_i)) begin
                        state <= IDLE;
                    end else if (wcnt == 4'd1) begin
                        state <= RESP;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (do_rty) begin
                        wb_rty_o      <= 1'b1;
                        cfg[RTY1_BIT] <= 1'b0;
                    end else if (do_err) begin
                        wb_err_o <= 1'b1;
                    end else begin
                        wb_ack_o  <= 1'b1;
                        acc_cnt_o <= acc_cnt_o + 8'd1;
                        if (!we_p0) begin
                            wb_dat_o <= is_cfg ? DWIDTH'(cfg_to_bus(cfg)) : rf_rdat;
                        end else if (is_cfg && sel_p0[0]) begin
                            cfg <= dat_p0[CFG_W-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_resp_mem.sv
// Directed self-checking bench for wb_resp_mem (DWIDTH=16, AWIDTH=3).
module tb_wb_resp_mem;

    logic        mstr_test_clk = 1'b0;
    logic        arst_i = 1'b0;
    logic [2:0]  wb_adr_i = '0;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        wb_we_i = 1'b0;
    logic [1:0]  wb_sel_i = '0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [7:0]  acc_cnt_o;

    int checks = 0;
    int errors = 0;

    localparam int K_NONE = 0;
    localparam int K_ACK  = 1;
    localparam int K_ERR  = 2;
    localparam int K_RTY  = 3;

    always #5 mstr_test_clk = ~mstr_test_clk;

    wb_resp_mem #(.DWIDTH(16), .AWIDTH(3)) dut (
        .wb_clk_i  (mstr_test_clk),
        .arst_i    (arst_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_we_i   (wb_we_i),
        .wb_sel_i  (wb_sel_i),
        .wb_stb_i  (wb_stb_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .wb_rty_o  (wb_rty_o),
        .acc_cnt_o (acc_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] terms();
        return {29'd0, wb_ack_o, wb_err_o, wb_rty_o};
    endfunction

    // Called at #1 after a rising edge; returns at #1 after a rising edge.
    // drop_after>0 releases cyc/stb that many edges after the request edge.
    task automatic xfer(input logic we, input logic [2:0] adr, input logic [15:0] dat,
                        input logic [1:0] sel, input int drop_after,
                        output int kind, output logic [15:0] rd, output int lat);
        kind = K_NONE;
        rd   = '0;
        lat  = 0;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        @(posedge mstr_test_clk);
        for (int i = 1; i <= 40; i++) begin
            @(posedge mstr_test_clk);
            #1;
            if (wb_ack_o || wb_err_o || wb_rty_o) begin
                lat  = i;
                kind = wb_ack_o ? K_ACK : (wb_err_o ? K_ERR : K_RTY);
                rd   = wb_dat_o;
                break;
            end
            if (drop_after > 0 && i == drop_after) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        if (kind != K_NONE) begin
            @(posedge mstr_test_clk);
            #1;
            check("term_one_cycle", terms(), 32'd0);
            check("dat_idle_zero", 32'(wb_dat_o), 32'd0);
        end
    endtask

    initial begin
        int          kind;
        int          lat;
        int          nack;
        logic [15:0] rd;

        // Reset state
        repeat (3) @(posedge mstr_test_clk);
        #1;
        check("rst_terms", terms(), 32'd0);
        check("rst_dat", 32'(wb_dat_o), 32'd0);
        check("rst_acc", 32'(acc_cnt_o), 32'd0);
        arst_i = 1'b1;

        // Reads of every address after reset; first one accepted on first edge
        for (int a = 0; a < 8; a++) begin
            xfer(1'b0, 3'(a), 16'h0, 2'b11, 0, kind, rd, lat);
            check($sformatf("rst_read_kind_%0d", a), 32'(kind), K_ACK);
            check($sformatf("rst_read_dat_%0d", a), 32'(rd), 32'h0);
            if (a == 0) check("first_lat", 32'(lat), 32'd1);
        end
        check("acc_after_8", 32'(acc_cnt_o), 32'd8);

        // WS=0 byte-lane writes
        xfer(1'b1, 3'd0, 16'h0000, 2'b11, 0, kind, rd, lat);
        check("cfg0_kind", 32'(kind), K_ACK);
        xfer(1'b1, 3'd3, 16'h1234, 2'b01, 0, kind, rd, lat);
        check("wr3_kind", 32'(kind), K_ACK);
        check("wr3_lat", 32'(lat), 32'd1);
        check("wr_ack_dat_zero", 32'(rd), 32'h0);
        xfer(1'b0, 3'd3, 16'h0, 2'b11, 0, kind, rd, lat);
        check("rd3_kind", 32'(kind), K_ACK);
        check("rd3_lat", 32'(lat), 32'd1);
        check("rd3_dat", 32'(rd), 32'h0034);
        xfer(1'b1, 3'd4, 16'hABCD, 2'b10, 0, kind, rd, lat);
        xfer(1'b0, 3'd4, 16'h0, 2'b11, 0, kind, rd, lat);
        check("rd4_hi_lane", 32'(rd), 32'hAB00);
        xfer(1'b1, 3'd6, 16'h5555, 2'b00, 0, kind, rd, lat);
        check("sel0_kind", 32'(kind), K_ACK);
        xfer(1'b0, 3'd6, 16'h0, 2'b11, 0, kind, rd, lat);
        check("sel0_dat", 32'(rd), 32'h0);
        check("acc_15", 32'(acc_cnt_o), 32'd15);

        // WS=3: new WS applies from next request; drop stb mid-wait
        xfer(1'b1, 3'd0, 16'h0003, 2'b11, 0, kind, rd, lat);
        check("cfg_ws3_lat_old", 32'(lat), 32'd1);
        xfer(1'b0, 3'd3, 16'h0, 2'b11, 0, kind, rd, lat);
        check("ws3_kind", 32'(kind), K_ACK);
        check("ws3_lat", 32'(lat), 32'd4);
        check("ws3_dat", 32'(rd), 32'h0034);
        xfer(1'b0, 3'd3, 16'h0, 2'b11, 2, kind, rd, lat);
        check("drop_kind", 32'(kind), K_NONE);
        check("drop_acc", 32'(acc_cnt_o), 32'd17);
        xfer(1'b0, 3'd0, 16'h0, 2'b11, 0, kind, rd, lat);
        check("cfg_rd_ws3", 32'(rd), 32'h0003);
        check("cfg_rd_ws3_lat", 32'(lat), 32'd4);

        // RTY1 | WP
        xfer(1'b1, 3'd0, 16'h0030, 2'b11, 0, kind, rd, lat);
        check("cfg30_lat_old", 32'(lat), 32'd4);
        xfer(1'b1, 3'd5, 16'hBEEF, 2'b11, 0, kind, rd, lat);
        check("rty_kind", 32'(kind), K_RTY);
        check("rty_lat", 32'(lat), 32'd1);
        check("rty_dat", 32'(rd), 32'h0);
        check("rty_acc", 32'(acc_cnt_o), 32'd19);
        xfer(1'b0, 3'd0, 16'h0, 2'b11, 0, kind, rd, lat);
        check("cfg_after_rty", 32'(rd), 32'h0020);
        xfer(1'b1, 3'd5, 16'hBEEF, 2'b11, 0, kind, rd, lat);
        check("err_kind", 32'(kind), K_ERR);
        check("err_dat", 32'(rd), 32'h0);
        xfer(1'b0, 3'd5, 16'h0, 2'b11, 0, kind, rd, lat);
        check("rd5_protected", 32'(rd), 32'h0);
        xfer(1'b1, 3'd0, 16'hFFC5, 2'b11, 0, kind, rd, lat);
        check("cfg_wr_under_wp", 32'(kind), K_ACK);
        xfer(1'b0, 3'd0, 16'h0, 2'b11, 0, kind, rd, lat);
        check("cfg_masked", 32'(rd), 32'h0005);
        check("cfg_ws5_lat", 32'(lat), 32'd6);
        check("acc_23", 32'(acc_cnt_o), 32'd23);

        // Reset in the middle of a WS=5 wait
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = 3'd3;
        @(posedge mstr_test_clk);
        repeat (2) @(posedge mstr_test_clk);
        #1;
        check("pre_rst_no_term", terms(), 32'd0);
        arst_i = 1'b0;
        #1;
        check("midrst_acc", 32'(acc_cnt_o), 32'd0);
        repeat (6) begin
            @(posedge mstr_test_clk);
            #1;
            check("midrst_no_term", terms(), 32'd0);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        arst_i   = 1'b1;
        xfer(1'b0, 3'd0, 16'h0, 2'b11, 0, kind, rd, lat);
        check("post_rst_cfg_kind", 32'(kind), K_ACK);
        check("post_rst_cfg", 32'(rd), 32'h0);
        check("post_rst_lat", 32'(lat), 32'd1);
        xfer(1'b0, 3'd3, 16'h0, 2'b11, 0, kind, rd, lat);
        check("post_rst_data", 32'(rd), 32'h0);
        check("post_rst_acc", 32'(acc_cnt_o), 32'd2);

        // 256 acked reads wrap the counter
        arst_i = 1'b0;
        @(posedge mstr_test_clk);
        #1;
        arst_i = 1'b1;
        nack = 0;
        for (int n = 0; n < 256; n++) begin
            xfer(1'b0, 3'd1, 16'h0, 2'b11, 0, kind, rd, lat);
            if (kind == K_ACK) nack++;
            if (n == 254) check("acc_255", 32'(acc_cnt_o), 32'd255);
        end
        check("wrap_acks", 32'(nack), 32'd256);
        check("acc_wrap", 32'(acc_cnt_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
